// File: rtl/uart_rx.sv
// uart_rx: oversampled 8N1 receiver with 3-sample majority vote and valid/ack hold handshake.
// Frames are re-armed through BREAK so a stuck-low line never produces spurious starts.
module uart_rx #(
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       baudtick,
   input  logic       rx,
   input  logic       rx_ack,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_busy,
   output logic       frame_error,
   output logic       overrun
);
   localparam int TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] V0   = TW'(OVERSAMPLE/2-1);
   localparam logic [TW-1:0] V1   = TW'(OVERSAMPLE/2);
   localparam logic [TW-1:0] V2   = TW'(OVERSAMPLE/2+1);
   localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE-1);

   typedef enum logic [2:0] {S_BREAK, S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t        r_state, w_next;
   logic [1:0]    r_sync;
   logic [TW-1:0] r_tcnt;
   logic [2:0]    r_bitcnt;
   logic [7:0]    r_shift;
   logic [1:0]    r_votes;
   logic          w_rs, w_busy, w_tick, w_vote_end, w_last, w_maj, w_good, w_ferr, w_load;

   assign w_rs       = r_sync[1];
   assign w_busy     = r_state inside {S_START, S_DATA, S_STOP};
   assign w_tick     = baudtick & w_busy;
   assign w_vote_end = w_tick & (r_tcnt == V2);
   assign w_last     = w_tick & (r_tcnt == LAST);
   // third sample arrives on the vote-end tick itself, so it joins the stored two here
   assign w_maj      = (r_votes + {1'b0, w_rs}) >= 2'd2;
   assign w_good     = (r_state == S_STOP) & w_vote_end & w_maj;
   assign w_ferr     = (r_state == S_STOP) & w_vote_end & ~w_maj;
   assign w_load     = w_good & (~rx_valid | rx_ack);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_BREAK: w_next = w_rs ? S_IDLE : S_BREAK;
         S_IDLE:  w_next = w_rs ? S_IDLE : S_START;
         S_START: w_next = (w_vote_end && w_maj) ? S_IDLE : w_last ? S_DATA : S_START;
         S_DATA:  w_next = (w_last && r_bitcnt == 3'd7) ? S_STOP : S_DATA;
         S_STOP:  w_next = w_vote_end ? (w_maj ? S_IDLE : S_BREAK) : S_STOP;
         default: w_next = S_BREAK;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_BREAK;
         r_sync      <= '0;
         r_tcnt      <= '0;
         r_bitcnt    <= '0;
         r_shift     <= '0;
         r_votes     <= '0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         rx_busy     <= 1'b0;
         frame_error <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         r_sync      <= {r_sync[0], rx};
         r_state     <= w_next;
         rx_busy     <= w_next inside {S_START, S_DATA, S_STOP};
         r_tcnt      <= (!w_busy || w_last) ? '0 : w_tick ? r_tcnt + 1'b1 : r_tcnt;
         r_bitcnt    <= !w_busy ? '0 : (r_state == S_DATA && w_last) ? r_bitcnt + 3'd1 : r_bitcnt;
         r_votes     <= (w_tick && r_tcnt == V0) ? {1'b0, w_rs} :
                        (w_tick && r_tcnt == V1) ? r_votes + {1'b0, w_rs} : r_votes;
         r_shift     <= (r_state == S_DATA && w_vote_end) ? {w_maj, r_shift[7:1]} : r_shift;
         frame_error <= w_ferr;
         overrun     <= w_good & rx_valid & ~rx_ack;
         rx_data     <= w_load ? r_shift : rx_data;
         rx_valid    <= w_load | (rx_valid & ~rx_ack);
      end
   end
endmodule
